pixel_job_dispatcher: RTL and testbench
=======================================

# pixel_job_dispatcher

Issues pixel coordinates (x, y) to up to four ray-tracing compute cores in strict round-robin order. The order matches the order in which the downstream pixel buffer collects results, so the output stream stays in raster order. The block sits upstream of the compute cores. It sequences one frame per `start` and tracks the pixels still in flight using the completion pulses from the stream output. It reports frame completion once every issued pixel has been emitted.

## Interface
Parameters:
- `MAX_CORES`, 4, number of core job ports (one-hot job_valid width)
- `X_W`, 10, width of x coordinate and frame_width
- `Y_W`, 10, width of y coordinate and frame_height

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle frame start request. Accepted only in IDLE.
- `frame_width` in X_W: pixels per line. Sampled on accepted start.
- `frame_height` in Y_W: lines per frame. Sampled on accepted start.
- `no_of_extra_cores` in 3: active cores = value+1. Sampled on start. Values >3 clamp to 3.
- `job_x` out X_W: x coordinate of the presented job.
- `job_y` out Y_W: y coordinate of the presented job.
- `job_last` out 1: the presented job is the final pixel of the frame.
- `job_valid` out MAX_CORES: one-hot. Bit i offers the job to core i.
- `job_ready` in MAX_CORES: core i accepts the job.
- `pix_done` in 1: one pulse per pixel emitted downstream (stream valid & ready).
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at frame completion.
- `outstanding` out X_W+Y_W+1: count of jobs issued but not yet completed.

## Operation
- State machine states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - `busy`=0, `job_valid`=0.
  - On `start`, latch the configuration, clear x, y and `core_idx`.
  - If width==0 or height==0, go to DONE. Otherwise go to DISPATCH.
- DISPATCH:
  - `job_valid[core_idx]`=1 with the current x and y.
  - `job_last` = (x==w-1 && y==h-1).
  - A job is accepted on `job_valid[core_idx] & job_ready[core_idx]`. On acceptance:
    - x increments. At x==w-1, x wraps to 0 and y increments.
    - `core_idx` increments, wrapping to 0 after the last active core.
    - `outstanding` increments.
  - Accepting the `job_last` job moves the FSM to DRAIN.
- Handshake rules:
  - Once asserted, a job stays stable (coordinates, index, job_last) until accepted. It is never retracted.
  - `job_ready` on any non-selected core is ignored.
  - Cores are never skipped. A stalled core stalls the whole dispatch.
- DRAIN: `job_valid`=0. When `outstanding`==0, go to DONE.
- DONE: `frame_done`=1 for exactly one cycle, then go to IDLE.
- `outstanding` arithmetic:
  - +1 on job accept, -1 on `pix_done`. Simultaneous events give a net change of zero.
  - `pix_done` when `outstanding`==0 is ignored. The counter saturates at 0 and never underflows.
  - `pix_done` in IDLE is ignored.
- `start` while `busy` is ignored. Config inputs are not re-sampled mid-frame.

## Timing
- Reset values:
  - State IDLE.
  - `job_valid`=0, `job_x`=0, `job_y`=0, `job_last`=0.
  - `busy`=0, `frame_done`=0, `outstanding`=0.
  - Internal `core_idx`=0.
- Reset mid-frame returns everything to the reset values immediately (asynchronously). Any partially issued frame is abandoned.
- All outputs are registered or decoded from registered state only. There is no combinational input-to-output path.
- Latencies and throughput:
  - `start` at cycle 0: `busy` and `job_valid` first assert at cycle 1.
  - With ready held high, one job per cycle. Next job presented the cycle after acceptance.
  - `frame_done` asserts the cycle after DRAIN sees `outstanding`==0.
  - For a zero-size frame: start at cycle 0, DONE at cycle 1, `frame_done` pulse at cycle 1, IDLE at cycle 2.
- DRAIN exit: if the last `pix_done` coincides with the `job_last` acceptance, `outstanding` is unchanged that cycle and DRAIN waits as normal.

## Test plan
- Nominal raster order:
  - Stimulus: width=4, height=2, `no_of_extra_cores`=1, all ready high.
  - Required jobs: (0,0)c0, (1,0)c1, (2,0)c0, (3,0)c1, (0,1)c0, (1,1)c1, (2,1)c0, (3,1)c1.
  - `job_last` asserts only on (3,1).
  - 8 `pix_done` pulses -> `outstanding` reaches 0 -> one `frame_done` pulse -> `busy`=0.
- Backpressure:
  - Stimulus: 4 cores, core2 ready low for 5 cycles.
  - Required: `job_valid`=4'b0100 with coordinates held stable for those 5 cycles; no other core's job_valid asserts.
- Zero-size frame and clamping:
  - Zero-size stimulus: width=0, height=5. Required: no `job_valid` ever, `frame_done` at cycle 1.
  - Clamp stimulus: `no_of_extra_cores`=7. Required: round-robin over c0..c3.
- Counter edges:
  - Stimulus: `pix_done` in IDLE, and `pix_done` simultaneous with a job accept when `outstanding`=3.
  - Required: counter stays 0 in IDLE; counter stays 3 on the simultaneous event; no underflow on an extra `pix_done` at 0.
- Start while busy: `start` pulsed mid-frame with different width -> ignored; the original frame dimensions are kept.
- Reset mid-frame: `aresetn` low after 3 jobs accepted -> all outputs return to reset values; next `start` begins at (0,0)c0.

Source files
------------

// File: rtl/pixel_job_dispatcher.sv
// Round-robin pixel job issuer: walks a frame in raster order, hands each pixel to the next
// active core in turn, and tracks in-flight pixels until the stream has emitted them all.
module pixel_job_dispatcher #(
   parameter int MAX_CORES = 4,
   parameter int X_W       = 10,
   parameter int Y_W       = 10
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 start,
   input  logic [X_W-1:0]       frame_width,
   input  logic [Y_W-1:0]       frame_height,
   input  logic [2:0]           no_of_extra_cores,
   output logic [X_W-1:0]       job_x,
   output logic [Y_W-1:0]       job_y,
   output logic                 job_last,
   output logic [MAX_CORES-1:0] job_valid,
   input  logic [MAX_CORES-1:0] job_ready,
   input  logic                 pix_done,
   output logic                 busy,
   output logic                 frame_done,
   output logic [X_W+Y_W:0]     outstanding
);

   localparam int CIDX_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
   localparam int OUT_W  = X_W + Y_W + 1;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

   state_t              state, state_next;
   logic [X_W-1:0]      w_cfg, x;
   logic [Y_W-1:0]      h_cfg, y;
   logic [CIDX_W-1:0]   core_idx, last_core;
   logic [OUT_W-1:0]    count;
   logic                accept, retire, at_line_end, at_last_pixel;

   // Highest usable core index; requests beyond the physical core count fold onto it.
   function automatic logic [CIDX_W-1:0] clamp_last_core(input logic [2:0] extra);
      if (int'(extra) > MAX_CORES - 1)
         return CIDX_W'(MAX_CORES - 1);
      return CIDX_W'(extra);
   endfunction

   assign accept        = (state == DISPATCH) && job_ready[core_idx];
   assign retire        = pix_done && (count != '0) && (state != IDLE);
   assign at_line_end   = (x == w_cfg - X_W'(1));
   assign at_last_pixel = at_line_end && (y == h_cfg - Y_W'(1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (start)
               state_next = (frame_width == '0 || frame_height == '0) ? DONE : DISPATCH;
         DISPATCH:
            if (accept && at_last_pixel)
               state_next = DRAIN;
         DRAIN:
            if (count == '0)
               state_next = DONE;
         DONE:
            state_next = IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   always_comb begin
      job_valid  = '0;
      job_last   = 1'b0;
      busy       = (state != IDLE);
      frame_done = (state == DONE);
      if (state == DISPATCH) begin
         job_valid[core_idx] = 1'b1;
         job_last            = at_last_pixel;
      end
   end

   // Coordinates and core index only move on acceptance, so a presented job never changes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_cfg     <= '0;
         h_cfg     <= '0;
         last_core <= '0;
         x         <= '0;
         y         <= '0;
         core_idx  <= '0;
         count     <= '0;
      end else begin
         if (state == IDLE && start) begin
            w_cfg     <= frame_width;
            h_cfg     <= frame_height;
            last_core <= clamp_last_core(no_of_extra_cores);
            x         <= '0;
            y         <= '0;
            core_idx  <= '0;
         end else if (accept) begin
            if (at_line_end) begin
               x <= '0;
               y <= y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
            core_idx <= (core_idx == last_core) ? '0 : core_idx + 1'b1;
         end
         if (accept && !retire)
            count <= count + 1'b1;
         else if (!accept && retire)
            count <= count - 1'b1;
      end
   end

   assign job_x       = x;
   assign job_y       = y;
   assign outstanding = count;

endmodule

// File: tb/tb_pixel_job_dispatcher.sv
// Randomized bench for pixel_job_dispatcher: a job-count based reference model checks all
// outputs every cycle, and directed scenarios pin the model with hand-computed job lists.
module tb_pixel_job_dispatcher;

   localparam int MAX_CORES = 4;
   localparam int X_W       = 10;
   localparam int Y_W       = 10;

   logic                 aclk = 1'b0;
   logic                 aresetn = 1'b0;
   logic                 start = 1'b0;
   logic [X_W-1:0]       frame_width = '0;
   logic [Y_W-1:0]       frame_height = '0;
   logic [2:0]           no_of_extra_cores = '0;
   logic [X_W-1:0]       job_x;
   logic [Y_W-1:0]       job_y;
   logic                 job_last;
   logic [MAX_CORES-1:0] job_valid;
   logic [MAX_CORES-1:0] job_ready = '0;
   logic                 pix_done = 1'b0;
   logic                 busy;
   logic                 frame_done;
   logic [X_W+Y_W:0]     outstanding;

   pixel_job_dispatcher #(.MAX_CORES(MAX_CORES), .X_W(X_W), .Y_W(Y_W)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start),
      .frame_width(frame_width), .frame_height(frame_height),
      .no_of_extra_cores(no_of_extra_cores),
      .job_x(job_x), .job_y(job_y), .job_last(job_last),
      .job_valid(job_valid), .job_ready(job_ready), .pix_done(pix_done),
      .busy(busy), .frame_done(frame_done), .outstanding(outstanding)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame is just job number k = 0..w*h-1 with x=k%w, y=k/w, core=k%cores.
   bit m_busy = 0, m_done = 0;
   int m_w = 0, m_h = 0, m_nc = 1, m_total = 0, m_issued = 0, m_out = 0;
   int acc_log[$];

   always @(negedge aclk) begin : model
      bit disp, acc, dec;
      int ex, ey, ec;
      if (!aresetn) begin
         m_busy = 0; m_done = 0; m_issued = 0; m_total = 0; m_out = 0;
         check("rst_job_valid", longint'(job_valid), 0);
         check("rst_job_x", longint'(job_x), 0);
         check("rst_job_y", longint'(job_y), 0);
         check("rst_job_last", longint'(job_last), 0);
         check("rst_busy", longint'(busy), 0);
         check("rst_frame_done", longint'(frame_done), 0);
         check("rst_outstanding", longint'(outstanding), 0);
      end else begin
         disp = m_busy && !m_done && (m_issued < m_total);
         ex = 0; ey = 0; ec = 0;
         if (disp) begin
            ex = m_issued % m_w;
            ey = m_issued / m_w;
            ec = m_issued % m_nc;
         end
         check("busy", longint'(busy), longint'(m_busy));
         check("frame_done", longint'(frame_done), longint'(m_done));
         check("outstanding", longint'(outstanding), longint'(m_out));
         check("job_valid", longint'(job_valid), disp ? (longint'(1) << ec) : 0);
         check("job_last", longint'(job_last), longint'(disp && (m_issued == m_total - 1)));
         if (disp) begin
            check("job_x", longint'(job_x), ex);
            check("job_y", longint'(job_y), ey);
         end
         if (!m_busy) begin
            if (start) begin
               m_w      = int'(frame_width);
               m_h      = int'(frame_height);
               m_nc     = (int'(no_of_extra_cores) > MAX_CORES - 1) ? MAX_CORES
                                                                     : int'(no_of_extra_cores) + 1;
               m_total  = m_w * m_h;
               m_issued = 0;
               m_busy   = 1;
               m_done   = (m_total == 0);
            end
         end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
         end else if (disp) begin
            acc = job_ready[ec];
            dec = pix_done && (m_out > 0);
            if (acc) begin
               acc_log.push_back(ex * 100 + ey * 10 + ec);
               m_issued++;
            end
            m_out = m_out + int'(acc) - int'(dec);
         end else begin
            if (m_out == 0)
               m_done = 1;
            else if (pix_done)
               m_out--;
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_start(input int w, input int h, input int nc);
      frame_width       = X_W'(w);
      frame_height      = Y_W'(h);
      no_of_extra_cores = 3'(nc);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Random ready/pix_done (and ignored start pulses) until the frame returns to idle.
   task automatic finish_frame(input int rdy_pct, input int pd_pct);
      int cyc = 0;
      while (busy && cyc < 3000) begin
         for (int i = 0; i < MAX_CORES; i++)
            job_ready[i] = ($urandom_range(99) < rdy_pct);
         pix_done = ($urandom_range(99) < pd_pct);
         if ($urandom_range(99) < 5) begin
            start       = 1'b1;
            frame_width = X_W'($urandom_range(9));
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start    = 1'b0;
      pix_done = 1'b0;
      check("frame_completes", longint'(busy), 0);
   endtask

   task automatic check_log(input string name, input int n, input int exp[8]);
      check({name, "_count"}, acc_log.size(), n);
      for (int i = 0; i < n && i < acc_log.size(); i++)
         check(name, acc_log[i], exp[i]);
   endtask

   initial begin
      int cyc;
      int w, h;
      aresetn = 1'b0;
      repeat (3) tick();
      aresetn = 1'b1;
      tick();
      check("reset_valid", longint'(job_valid), 0);
      check("reset_outstanding", longint'(outstanding), 0);

      // pix_done while idle must not move the counter
      pix_done = 1'b1;
      repeat (3) tick();
      pix_done = 1'b0;
      check("idle_pix_done", longint'(outstanding), 0);

      // nominal 4x2 frame over two cores
      acc_log.delete();
      job_ready = '1;
      do_start(4, 2, 1);
      cyc = 0;
      while (job_valid != '0 && cyc < 100) begin tick(); cyc++; end
      check("nom_outstanding_full", longint'(outstanding), 8);
      job_ready = '0;
      pix_done  = 1'b1;
      repeat (9) tick();
      check("nom_frame_done", longint'(frame_done), 1);
      check("nom_no_underflow", longint'(outstanding), 0);
      pix_done = 1'b0;
      tick();
      check("nom_idle", longint'(busy), 0);
      check_log("nom_jobs", 8, '{0, 101, 200, 301, 10, 111, 210, 311});

      // backpressure on core 2
      job_ready = 4'b1011;
      do_start(8, 1, 3);
      cyc = 0;
      while (job_valid != 4'b0100 && cyc < 20) begin tick(); cyc++; end
      repeat (5) begin
         check("bp_valid", longint'(job_valid), 4);
         check("bp_x", longint'(job_x), 2);
         check("bp_y", longint'(job_y), 0);
         tick();
      end
      finish_frame(80, 40);

      // simultaneous accept and pix_done at outstanding == 3
      job_ready = '1;
      do_start(8, 1, 3);
      repeat (3) tick();
      check("cnt_three", longint'(outstanding), 3);
      pix_done = 1'b1;
      tick();
      pix_done = 1'b0;
      check("cnt_simultaneous", longint'(outstanding), 3);
      finish_frame(100, 50);

      // clamp: 7 extra cores means four cores
      acc_log.delete();
      job_ready = '1;
      do_start(6, 1, 7);
      finish_frame(100, 30);
      check_log("clamp_jobs", 6, '{0, 101, 202, 303, 400, 501, 0, 0});

      // zero-size frame
      acc_log.delete();
      do_start(0, 5, 0);
      check("zero_frame_done", longint'(frame_done), 1);
      check("zero_valid", longint'(job_valid), 0);
      tick();
      check("zero_idle", longint'(busy), 0);
      check("zero_no_jobs", acc_log.size(), 0);

      // start while busy with a different width
      acc_log.delete();
      job_ready = '1;
      do_start(5, 2, 1);
      repeat (3) tick();
      frame_width  = X_W'(3);
      frame_height = Y_W'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_frame(70, 40);
      check("sb_count", acc_log.size(), 10);
      if (acc_log.size() == 10)
         check("sb_last_job", acc_log[9], 411);

      // asynchronous reset mid-frame
      job_ready = '1;
      do_start(6, 2, 3);
      repeat (3) tick();
      aresetn = 1'b0;
      #1;
      check("mid_rst_valid", longint'(job_valid), 0);
      check("mid_rst_outstanding", longint'(outstanding), 0);
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_x", longint'(job_x), 0);
      tick();
      aresetn = 1'b1;
      acc_log.delete();
      do_start(4, 1, 3);
      check("post_rst_valid", longint'(job_valid), 1);
      check("post_rst_x", longint'(job_x), 0);
      check("post_rst_y", longint'(job_y), 0);
      finish_frame(100, 50);
      check_log("post_rst_jobs", 4, '{0, 101, 202, 303, 0, 0, 0, 0});

      // randomized frames
      repeat (10) begin
         acc_log.delete();
         w = $urandom_range(7, 1);
         h = $urandom_range(5, 1);
         do_start(w, h, $urandom_range(7));
         finish_frame($urandom_range(90, 40), $urandom_range(60, 20));
         check("rand_job_count", acc_log.size(), w * h);
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
